// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial WIDTH-bit adder sequencer driving one shared full-adder bit slice
// Defining SERIAL_ADD_OVF_EN adds the registered signed-overflow output OVF.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
  output logic             OVF,
`endif
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_nx;
  logic [WIDTH-1:0] s_next;

  // The single shared full-adder slice, always fed from the operand LSBs.
  assign sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nx = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign s_next   = {sum_bit, s_sh[WIDTH-1:1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      COUT  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      OVF   <= 1'b0;
`endif
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= CIN;
            s_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Abort wins even on the final bit, so a cancelled op never touches the results.
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            s_sh  <= s_next;
            carry <= carry_nx;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
              S     <= s_next;
              COUT  <= carry_nx;
`ifdef SERIAL_ADD_OVF_EN
              OVF   <= carry ^ carry_nx;
`endif
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - scoreboard bench for serial_add_seq (WIDTH=8)
// Covers OVF when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic             abort;
  logic             CIN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             COUT;
`ifdef SERIAL_ADD_OVF_EN
  logic             OVF;
`endif

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .abort (abort),
    .CIN   (CIN),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
`ifdef SERIAL_ADD_OVF_EN
    .OVF   (OVF),
`endif
    .COUT  (COUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    exp_t e;
    logic [WIDTH:0] sum;
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.s    = sum[WIDTH-1:0];
    e.cout = sum[WIDTH];
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_S"}, 32'(S), 32'(e.s));
      chk({tag, "_COUT"}, 32'(COUT), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_OVF"}, 32'(OVF), 32'(e.ovf));
`endif
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
    int n;
    A = a; B = b; CIN = cin; start = 1'b1;
    sb.push_back(model(a, b, cin));
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; CIN = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(WIDTH));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_result(tag);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             cv;

    RST = 1'b1; start = 1'b0; abort = 1'b0; CIN = 1'b0; A = '0; B = '0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_COUT", 32'(COUT), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_OVF", 32'(OVF), 32'd0);
`endif

    run_op("op_5a_3c", 8'h5A, 8'h3C, 1'b0);
    run_op("op_ff_01", 8'hFF, 8'h01, 1'b0);
    run_op("op_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
    run_op("op_01_01", 8'h01, 8'h01, 1'b0);

    // Abort on the 3rd RUN cycle: accept at edge 0, abort sampled at edge 3.
    A = 8'h10; B = 8'h20; CIN = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_S_hold", 32'(S), 32'h02);
    run_op("after_abort", 8'h33, 8'h44, 1'b1);

    // Start held high with operands changing every cycle: accepts at 0, 10, 20.
    start = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      av = 8'(cyc * 37 + 5);
      bv = 8'(cyc * 91 + 3);
      cv = cyc[0];
      A = av; B = bv; CIN = cv;
      if (cyc % 10 == 0) sb.push_back(model(av, bv, cv));
      tick();
      chk($sformatf("held_busy_%0d", cyc), 32'(busy), 32'((cyc % 10) < 8));
      chk($sformatf("held_done_%0d", cyc), 32'(done), 32'((cyc % 10) == 8));
      if (cyc % 10 == 8) check_result($sformatf("held_%0d", cyc));
    end
    start = 1'b0;
    tick();
    chk("held_sb_empty", 32'(sb.size()), 32'd0);

    // Reset pulsed between edges in the middle of RUN.
    A = 8'h7F; B = 8'h7F; CIN = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_S", 32'(S), 32'd0);
    chk("mid_rst_COUT", 32'(COUT), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("mid_rst_OVF", 32'(OVF), 32'd0);
`endif
    #1 RST = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_op("op_80_80", 8'h80, 8'h80, 1'b0);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
